// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: mode and direction
// encodings plus the pattern value loaded whenever the mode changes.
package led_pkg;

    // Widest LED bank the reload helper can describe; callers truncate.
    localparam int MAX_LED_W = 32;

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_SHIFT  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    // Mode sequence wraps from BOUNCE back to UP.
    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

    // Pattern shown immediately after entering mode m.
    function automatic logic [MAX_LED_W-1:0] reload_value(input mode_t m);
        logic [MAX_LED_W-1:0] value;
        case (m)
            MODE_UP:   value = '0;
            MODE_DOWN: value = '1;
            default:   value = {{(MAX_LED_W-1){1'b0}}, 1'b1};
        endcase
        return value;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability filter and a
// one-cycle pulse on each accepted press (debounced high-to-low edge).
module btn_debounce #(
    parameter int DEB_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, giving a real 2-stage chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= btn_n;
            sync_b <= sync_a;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_b;
                press <= ~sync_b;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: a prescaler produces a step strobe that advances
// one of four patterns; debounced buttons cycle the mode and pause stepping.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CLK_HZ     = 27000000,
    parameter int TICK_HZ    = 2,
    parameter int LED_W      = 6,
    parameter int DEB_CYCLES = 270000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_mode_n,
    input  logic             btn_pause_n,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic             tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic             mode_press;
    logic             pause_press;

    mode_t            mode_q, mode_d;
    dir_t             dir_q, dir_d;
    logic             paused_q, paused_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [LED_W-1:0] pattern_q, pattern_d;

    logic [LED_W-1:0] step_pattern;
    dir_t             step_dir;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_mode_n),
        .press (mode_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_pause_n),
        .press (pause_press)
    );

    assign tick = (presc_q == PRESC_LAST) && !paused_q;
    assign led  = ~pattern_q;
    assign mode = mode_q;

    // Pattern one step ahead in the current mode.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        step_pattern = pattern_q;
        step_dir     = dir_q;
        case (mode_q)
            MODE_UP:   step_pattern = pattern_q + LED_W'(1);
            MODE_DOWN: step_pattern = pattern_q - LED_W'(1);
            MODE_SHIFT: step_pattern = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
            MODE_BOUNCE: begin
                if (dir_q == DIR_LEFT) begin
                    step_pattern = pattern_q << 1;
                    if (step_pattern[LED_W-1]) step_dir = DIR_RIGHT;
                end else begin
                    step_pattern = pattern_q >> 1;
                    if (step_pattern[0]) step_dir = DIR_LEFT;
                end
            end
            default: ;
        endcase
    end

    // Next state: a mode press overrides any coincident tick step.
    always_comb begin
        mode_d    = mode_q;
        dir_d     = dir_q;
        presc_d   = presc_q;
        pattern_d = pattern_q;
        paused_d  = paused_q ^ pause_press;
        if (mode_press) begin
            mode_d    = next_mode(mode_q);
            pattern_d = LED_W'(reload_value(next_mode(mode_q)));
            presc_d   = '0;
            dir_d     = DIR_LEFT;
        end else if (tick) begin
            pattern_d = step_pattern;
            dir_d     = step_dir;
            presc_d   = '0;
        end else if (!paused_q) begin
            presc_d = presc_q + PW'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_UP;
            dir_q     <= DIR_LEFT;
            paused_q  <= 1'b0;
            presc_q   <= '0;
            pattern_q <= '0;
        end else begin
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            paused_q  <= paused_d;
            presc_q   <= presc_d;
            pattern_q <= pattern_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with DIV=4, LED_W=4, DEB_CYCLES=3.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode_n;
    logic       btn_pause_n;
    logic [3:0] led;
    logic [1:0] mode;
    logic       tick;

    int checks = 0;
    int errors = 0;

    logic [3:0] bounce_seq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
    logic [3:0] shift_seq  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    led_pattern_gen #(
        .CLK_HZ     (8),
        .TICK_HZ    (2),
        .LED_W      (4),
        .DEB_CYCLES (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_mode_n  (btn_mode_n),
        .btn_pause_n (btn_pause_n),
        .led         (led),
        .mode        (mode),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance on falling edges until tick is seen; n = falling edges waited.
    task automatic wait_tick(output int n);
        n = 0;
        while (tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("tick_arrives", {31'd0, tick}, 32'd1);
    endtask

    initial begin
        int         n;
        int         bad_tick;
        int         bad_led;
        logic [3:0] e;

        rst         = 1'b1;
        btn_mode_n  = 1'b1;
        btn_pause_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_led", led, 4'b1111);
        check("rst_mode", mode, 2'd0);
        check("rst_tick", tick, 1'b0);
        #2 rst = 1'b0;
        @(negedge clk);

        // Count up through a full wrap.
        for (int i = 0; i < 20; i++) begin
            wait_tick(n);
            if (i > 0) check("up_interval", n, 3);
            e = ~4'(i);
            check("up_led", led, e);
            @(negedge clk);
        end

        // Mode press to COUNT_DOWN: latency, reload, first step, single press.
        btn_mode_n = 1'b0;
        repeat (5) @(negedge clk);
        check("down_latency", mode, 2'd0);
        @(negedge clk);
        check("down_mode", mode, 2'd1);
        check("down_reload", led, 4'b0000);
        btn_mode_n = 1'b1;
        wait_tick(n);
        check("down_presc_clear", n, 3);
        check("down_pre_step", led, 4'b0000);
        @(negedge clk);
        check("down_step", led, 4'b0001);
        repeat (10) @(negedge clk);
        check("down_one_press", mode, 2'd1);

        // SHIFT: rotate left with wrap.
        btn_mode_n = 1'b0;
        repeat (6) @(negedge clk);
        check("shift_mode", mode, 2'd2);
        check("shift_reload", led, 4'b1110);
        btn_mode_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_tick(n);
            e = ~shift_seq[k];
            check("shift_led", led, e);
            @(negedge clk);
        end

        // BOUNCE: one-hot walk with single-tick end positions.
        btn_mode_n = 1'b0;
        repeat (6) @(negedge clk);
        check("bounce_mode", mode, 2'd3);
        check("bounce_reload", led, 4'b1110);
        btn_mode_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_tick(n);
            e = ~bounce_seq[k % 6];
            check("bounce_led", led, e);
            @(negedge clk);
        end

        // Two-cycle glitch: no mode change and no reload.
        btn_mode_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        btn_mode_n = 1'b1;
        for (int k = 8; k < 12; k++) begin
            wait_tick(n);
            e = ~bounce_seq[k % 6];
            check("glitch_led", led, e);
            @(negedge clk);
        end
        check("glitch_mode", mode, 2'd3);

        // Pause lands with the prescaler held at 2.
        btn_pause_n = 1'b0;
        repeat (3) @(negedge clk);
        check("pause_pre_tick", tick, 1'b1);
        check("pause_pre_led", led, 4'b1110);
        @(negedge clk);
        check("pause_pre_step", led, 4'b1101);
        @(negedge clk);
        @(negedge clk);
        btn_pause_n = 1'b1;
        bad_tick = 0;
        bad_led  = 0;
        repeat (100) begin
            @(negedge clk);
            if (tick !== 1'b0) bad_tick++;
            if (led !== 4'b1101) bad_led++;
        end
        btn_pause_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (tick !== 1'b0) bad_tick++;
            if (led !== 4'b1101) bad_led++;
        end
        check("pause_no_tick", bad_tick, 0);
        check("pause_frozen", bad_led, 0);
        @(negedge clk);
        btn_pause_n = 1'b1;
        check("resume_no_tick_yet", tick, 1'b0);
        check("resume_led_held", led, 4'b1101);
        @(negedge clk);
        check("resume_tick", tick, 1'b1);
        check("resume_pre_step", led, 4'b1101);
        @(negedge clk);
        check("resume_step", led, 4'b1011);

        // Reset pulsed between clock edges takes effect immediately.
        #2 rst = 1'b1;
        #1;
        check("async_rst_led", led, 4'b1111);
        check("async_rst_mode", mode, 2'd0);
        check("async_rst_tick", tick, 1'b0);
        #1 rst = 1'b0;
        wait_tick(n);
        check("post_rst_interval", n, 3);
        check("post_rst_pre_step", led, 4'b1111);
        @(negedge clk);
        check("post_rst_step", led, 4'b1110);

        // Button already held when reset releases.
        rst        = 1'b1;
        btn_mode_n = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("held_rst_latency", mode, 2'd0);
        @(negedge clk);
        check("held_rst_mode", mode, 2'd1);
        check("held_rst_reload", led, 4'b0000);
        btn_mode_n = 1'b1;
        repeat (10) @(negedge clk);
        check("held_rst_one_press", mode, 2'd1);

        // Simultaneous mode and pause presses.
        btn_mode_n  = 1'b0;
        btn_pause_n = 1'b0;
        repeat (6) @(negedge clk);
        check("both_mode", mode, 2'd2);
        check("both_reload", led, 4'b1110);
        btn_mode_n  = 1'b1;
        btn_pause_n = 1'b1;
        bad_tick = 0;
        bad_led  = 0;
        repeat (20) begin
            @(negedge clk);
            if (tick !== 1'b0) bad_tick++;
            if (led !== 4'b1110) bad_led++;
        end
        check("both_paused_tick", bad_tick, 0);
        check("both_paused_led", bad_led, 0);

        // Mode press while paused reloads and stays paused.
        btn_mode_n = 1'b0;
        repeat (6) @(negedge clk);
        check("paused_mode", mode, 2'd3);
        check("paused_reload", led, 4'b1110);
        btn_mode_n = 1'b1;
        bad_tick = 0;
        repeat (20) begin
            @(negedge clk);
            if (tick !== 1'b0) bad_tick++;
        end
        check("paused_still", bad_tick, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 27000000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter TICK_HZ, default 2, meaning the pattern step rate in Hz.
REQ-003 The block SHALL have parameter LED_W, default 6, meaning the LED count (minimum 2).
REQ-004 The block SHALL have parameter DEB_CYCLES, default 270000, meaning the clock cycles a button level must be stable before it is accepted.
REQ-005 Port clk  input  1  SHALL be the single clock; all state SHALL be on its rising edge.
REQ-006 Port rst  input  1  SHALL be the reset, asynchronous, active-high.
REQ-007 Port btn_mode_n  input  1  SHALL be the raw, asynchronous, active-low mode button.
REQ-008 Port btn_pause_n  input  1  SHALL be the raw, asynchronous, active-low pause button.
REQ-009 Port led  output  LED_W  SHALL be the LED drive, active-low (0 = lit).
REQ-010 Port mode  output  2  SHALL be the current mode.
REQ-011 Port tick  output  1  SHALL be a one-cycle step strobe.

Function
REQ-012 The prescaler SHALL count 0..DIV-1, with DIV = CLK_HZ/TICK_HZ and width $clog2(DIV); when it is at DIV-1 and not paused it SHALL assert tick for 1 cycle and wrap to 0.
REQ-013 The internal pattern register (LED_W bits) SHALL update only on tick; led SHALL equal ~pattern combinationally.
REQ-014 In mode 0, COUNT_UP, the pattern SHALL step to pattern+1 mod 2^LED_W (all-ones wraps to 0).
REQ-015 In mode 1, COUNT_DOWN, the pattern SHALL step to pattern-1 mod 2^LED_W (0 wraps to all-ones).
REQ-016 In mode 2, SHIFT, the pattern SHALL be one-hot and rotate left; bit LED_W-1 SHALL wrap to bit 0.
REQ-017 In mode 3, BOUNCE, the pattern SHALL be one-hot and step in a direction flag, initially left; on reaching bit LED_W-1 or bit 0 the direction SHALL reverse, with no repeated position, so the end bit is shown for exactly 1 tick.
REQ-018 Each button SHALL pass through a 2-flop synchroniser, then be accepted only after DEB_CYCLES consecutive equal samples; a debounced high-to-low transition SHALL produce a one-cycle press pulse.
REQ-019 A mode press SHALL set mode to mode+1 mod 4 in the next cycle, and SHALL also clear the prescaler to 0, set the direction to left, and load the pattern with: COUNT_UP 0, COUNT_DOWN all-ones, SHIFT/BOUNCE 1.
REQ-020 A pause press SHALL toggle the paused flag; while paused the prescaler and pattern SHALL hold and tick SHALL be 0; on resume counting SHALL continue from the held prescaler value.
REQ-021 If a mode press and a tick coincide, the mode press SHALL win: the reload values apply and the tick step is discarded.
REQ-022 Simultaneous mode and pause presses SHALL both take effect in the same cycle.
REQ-023 A button held low SHALL generate exactly one press; a release SHALL generate none.
REQ-024 A mode press while paused SHALL change mode and reload the pattern, and paused SHALL remain set.

Reset
REQ-025 While rst=1, regardless of clk, the block SHALL hold: pattern 0, mode 0, paused 0, direction left, prescaler 0, debounce counters 0, synchroniser and debounced levels 1 (released), tick 0, led all-ones.
REQ-026 A button already held low when rst is released SHALL produce one press after DEB_CYCLES+2 cycles.

Structure
REQ-027 Package led_pkg SHALL hold the mode encodings (MODE_UP=0, MODE_DOWN=1, MODE_SHIFT=2, MODE_BOUNCE=3) and the per-mode reload-value function.
REQ-028 One sub-module, btn_debounce (parameter DEB_CYCLES; ports clk, rst, btn_n, press), SHALL be instantiated twice.

Verification
REQ-029 The bench SHALL use CLK_HZ=8, TICK_HZ=2, LED_W=4, DEB_CYCLES=3, so DIV=4.
REQ-030 Reset then run 20 ticks -> tick every 4 cycles; pattern 0,1,...,15 then 0; led = ~pattern.
REQ-031 Mode button low for 6 cycles -> exactly one press; mode=1; led=0000 (pattern 1111); next tick pattern 1110.
REQ-032 Three mode presses to reach BOUNCE -> pattern 0001,0010,0100,1000,0100,0010,0001,0010 on successive ticks.
REQ-033 Mode button glitch low for 2 cycles -> no mode change, no reload.
REQ-034 Pause press, wait 100 cycles, pause press again -> pattern frozen and tick=0 throughout the pause; first tick after resume arrives after DIV minus the held prescaler value cycles.
REQ-035 rst pulsed between clock edges mid-count -> led=1111 and mode=0 immediately, before the next clk edge.
